// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_burst_ctrl
// Brief    : Cache-line burst engine: 4-word writeback and/or 4-word fill
//            with per-bank busy stalls and a fixed-latency read return path.
// Revision : 1.0 - initial release
// ============================================================================
module mem_burst_ctrl #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic [12:0]       wb_line,
    input  logic [12:0]       fill_line,
    input  logic [DATA_W-1:0] cache_data,
    output logic [1:0]        cache_offset,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [3:0]        busy,
    input  logic              mem_err,
    output logic              fill_valid,
    output logic [1:0]        fill_offset,
    output logic [DATA_W-1:0] fill_data,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]             r_state;
    logic [1:0]             r_offset;
    logic                   r_fill_pend;
    logic                   r_err;
    logic [12:0]            r_wb_line;
    logic [12:0]            r_fill_line;
    logic [RD_LAT-1:0]      r_ret_vld;
    logic [RD_LAT-1:0][1:0] r_ret_off;

    logic                   w_issue;
    logic [1:0]             w_ret_off_in;
    logic                   w_ret_pending;

    always_comb begin
        w_issue      = ((r_state == S_WB) || (r_state == S_RD)) && !busy[r_offset];
        mem_wr       = w_issue && (r_state == S_WB);
        mem_rd       = w_issue && (r_state == S_RD);
        cache_offset = (r_state == S_WB) ? r_offset : 2'd0;
        mem_data_out = (r_state == S_WB) ? cache_data : '0;
        case (r_state)
            S_WB:    mem_addr = {r_wb_line, r_offset, 1'b0};
            S_RD:    mem_addr = {r_fill_line, r_offset, 1'b0};
            default: mem_addr = 16'h0000;
        endcase
        w_ret_off_in = mem_rd ? r_offset : 2'd0;
        fill_valid   = r_ret_vld[RD_LAT-1];
        fill_offset  = r_ret_off[RD_LAT-1];
        fill_data    = fill_valid ? mem_data_in : '0;
        stall        = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        err          = (r_state == S_DONE) && r_err;
    end

    // Return path: one {valid, offset} slot per cycle, oldest at the top.
    generate
        if (RD_LAT == 1) begin : g_ret_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ret_vld <= '0;
                    r_ret_off <= '0;
                end else begin
                    r_ret_vld    <= mem_rd;
                    r_ret_off[0] <= w_ret_off_in;
                end
            end
            assign w_ret_pending = 1'b0;
        end else begin : g_ret_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ret_vld <= '0;
                    r_ret_off <= '0;
                end else begin
                    r_ret_vld <= {r_ret_vld[RD_LAT-2:0], mem_rd};
                    r_ret_off <= {r_ret_off[RD_LAT-2:0], w_ret_off_in};
                end
            end
            assign w_ret_pending = |r_ret_vld[RD_LAT-2:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_offset    <= 2'd0;
            r_fill_pend <= 1'b0;
            r_err       <= 1'b0;
            r_wb_line   <= 13'd0;
            r_fill_line <= 13'd0;
        end else begin
            if ((w_issue || fill_valid) && mem_err) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_wr || start_rd) begin
                        r_wb_line   <= wb_line;
                        r_fill_line <= fill_line;
                        r_fill_pend <= start_wr && start_rd;
                        r_offset    <= 2'd0;
                        r_state     <= start_wr ? S_WB : S_RD;
                    end
                end
                S_WB: begin
                    if (w_issue) begin
                        if (r_offset == 2'd3) begin
                            r_offset    <= 2'd0;
                            r_fill_pend <= 1'b0;
                            r_state     <= r_fill_pend ? S_RD : S_DONE;
                        end else begin
                            r_offset <= r_offset + 2'd1;
                        end
                    end
                end
                S_RD: begin
                    if (w_issue) begin
                        if (r_offset == 2'd3) begin
                            r_offset <= 2'd0;
                            r_state  <= S_DRAIN;
                        end else begin
                            r_offset <= r_offset + 2'd1;
                        end
                    end
                end
                // Leave once only the final return is left, i.e. on its fill_valid cycle.
                S_DRAIN: begin
                    if (!w_ret_pending) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_burst_ctrl
// Brief    : Self-checking bench for mem_burst_ctrl: vector table, directed
//            corner sequences and random traffic against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_burst_ctrl;

    localparam int RD_LAT = 2;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_wr;
    logic              start_rd;
    logic [12:0]       wb_line;
    logic [12:0]       fill_line;
    logic [DATA_W-1:0] cache_data;
    logic [1:0]        cache_offset;
    logic [15:0]       mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data_in;
    logic [3:0]        busy;
    logic              mem_err;
    logic              fill_valid;
    logic [1:0]        fill_offset;
    logic [DATA_W-1:0] fill_data;
    logic              stall;
    logic              done;
    logic              err;

    logic [15:0]       cd_base;

    always #5 clk = ~clk;

    // The cache returns a word whose value identifies the requested offset.
    assign cache_data = cd_base ^ {14'd0, cache_offset};

    mem_burst_ctrl #(.RD_LAT(RD_LAT), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_wr     (start_wr),
        .start_rd     (start_rd),
        .wb_line      (wb_line),
        .fill_line    (fill_line),
        .cache_data   (cache_data),
        .cache_offset (cache_offset),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_data_in  (mem_data_in),
        .busy         (busy),
        .mem_err      (mem_err),
        .fill_valid   (fill_valid),
        .fill_offset  (fill_offset),
        .fill_data    (fill_data),
        .stall        (stall),
        .done         (done),
        .err          (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sc    = 0;
    int done_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Transaction model: a line request becomes a queue of word operations;
    // each read schedules a return RD_LAT cycles after it issues.
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  off;
    } op_t;

    typedef struct {
        int         due;
        logic [1:0] off;
    } ret_t;

    op_t  ops[$];
    ret_t rets[$];
    int   m_mode = 0;   // 0 idle, 1 transferring, 2 completion cycle
    bit   m_err  = 1'b0;

    task automatic m_reset();
        ops.delete();
        rets.delete();
        m_mode = 0;
        m_err  = 1'b0;
    endtask

    task automatic step();
        op_t h;
        bit  act;
        bit  iss;
        bit  fv;
        h = '{wr: 1'b0, addr: 16'h0, off: 2'd0};
        #4;
        act = (m_mode == 1) && (ops.size() > 0);
        if (act) h = ops[0];
        iss = act && !busy[h.off];
        fv  = (rets.size() > 0) && (rets[0].due == cyc);
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, iss && h.wr});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, iss && !h.wr});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, act ? h.addr : 16'h0});
        chk("cache_offset", {30'd0, cache_offset}, {30'd0, (act && h.wr) ? h.off : 2'd0});
        chk("fill_valid", {31'd0, fill_valid}, {31'd0, fv});
        if (fv) begin
            chk("fill_offset", {30'd0, fill_offset}, {30'd0, rets[0].off});
            chk("fill_data", {16'd0, fill_data}, {16'd0, mem_data_in});
        end
        if (iss && h.wr) chk("mem_data_out", {16'd0, mem_data_out}, {16'd0, cd_base ^ {14'd0, h.off}});
        chk("stall", {31'd0, stall}, {31'd0, m_mode != 0});
        chk("done", {31'd0, done}, {31'd0, m_mode == 2});
        chk("err", {31'd0, err}, {31'd0, (m_mode == 2) && m_err});
        if (done && done_cyc < 0) done_cyc = sc;
        if (rst) begin
            m_reset();
        end else begin
            if (m_mode == 1 && mem_err && (iss || fv)) m_err = 1'b1;
            if (iss) begin
                void'(ops.pop_front());
                if (!h.wr) rets.push_back('{due: cyc + RD_LAT, off: h.off});
            end
            if (fv) void'(rets.pop_front());
            case (m_mode)
                0: begin
                    if (start_wr || start_rd) begin
                        m_err = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (start_wr) ops.push_back('{wr: 1'b1, addr: {wb_line, k[1:0], 1'b0}, off: k[1:0]});
                        end
                        for (int k = 0; k < 4; k++) begin
                            if (start_rd) ops.push_back('{wr: 1'b0, addr: {fill_line, k[1:0], 1'b0}, off: k[1:0]});
                        end
                        m_mode = 1;
                    end
                end
                1: if (ops.size() == 0 && rets.size() == 0) m_mode = 2;
                default: m_mode = 0;
            endcase
        end
        cyc++;
        sc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          swr;
        bit          srd;
        logic [3:0]  busy;
        bit          merr;
        bit          e_wr;
        bit          e_rd;
        logic [15:0] e_addr;
        logic [1:0]  e_coff;
        bit          e_fv;
        logic [1:0]  e_foff;
        bit          e_stall;
        bit          e_done;
        bit          e_err;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // Read fill of line 0x0010, no stalls.
        tbl[0]  = '{0, 1, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 0, 0, 0};
        tbl[1]  = '{0, 0, 4'h0, 0,  0, 1, 16'h0080, 2'd0, 0, 2'd0, 1, 0, 0};
        tbl[2]  = '{0, 0, 4'h0, 0,  0, 1, 16'h0082, 2'd0, 0, 2'd0, 1, 0, 0};
        tbl[3]  = '{0, 0, 4'h0, 0,  0, 1, 16'h0084, 2'd0, 1, 2'd0, 1, 0, 0};
        tbl[4]  = '{0, 0, 4'h0, 0,  0, 1, 16'h0086, 2'd0, 1, 2'd1, 1, 0, 0};
        tbl[5]  = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 1, 2'd2, 1, 0, 0};
        tbl[6]  = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 1, 2'd3, 1, 0, 0};
        tbl[7]  = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 1, 1, 0};
        tbl[8]  = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 0, 0, 0};
        // Writeback of line 0x0001 with an error in the second write.
        tbl[9]  = '{1, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 0, 0, 0};
        tbl[10] = '{0, 0, 4'h0, 0,  1, 0, 16'h0008, 2'd0, 0, 2'd0, 1, 0, 0};
        tbl[11] = '{0, 0, 4'h0, 1,  1, 0, 16'h000A, 2'd1, 0, 2'd0, 1, 0, 0};
        tbl[12] = '{0, 0, 4'h0, 0,  1, 0, 16'h000C, 2'd2, 0, 2'd0, 1, 0, 0};
        tbl[13] = '{0, 0, 4'h0, 0,  1, 0, 16'h000E, 2'd3, 0, 2'd0, 1, 0, 0};
        tbl[14] = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 1, 1, 1};
        tbl[15] = '{0, 0, 4'h0, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 0, 0, 0};
        // Writeback whose first word meets a busy bank 0.
        tbl[16] = '{1, 0, 4'h1, 0,  0, 0, 16'h0000, 2'd0, 0, 2'd0, 0, 0, 0};
        tbl[17] = '{0, 0, 4'h1, 0,  0, 0, 16'h0008, 2'd0, 0, 2'd0, 1, 0, 0};
        tbl[18] = '{0, 0, 4'h0, 0,  1, 0, 16'h0008, 2'd0, 0, 2'd0, 1, 0, 0};

        rst = 1'b1; start_wr = 1'b0; start_rd = 1'b0; busy = 4'h0; mem_err = 1'b0;
        wb_line = 13'h0001; fill_line = 13'h0010;
        cd_base = 16'h1234; mem_data_in = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_cache_offset", {30'd0, cache_offset}, 32'd0);
        chk("rst_mem_data_out", {16'd0, mem_data_out}, 32'd0);
        chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
        chk("rst_fill_offset", {30'd0, fill_offset}, 32'd0);
        chk("rst_fill_data", {16'd0, fill_data}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            start_wr = tbl[i].swr;
            start_rd = tbl[i].srd;
            busy     = tbl[i].busy;
            mem_err  = tbl[i].merr;
            #4;
            chk("t_mem_wr", {31'd0, mem_wr}, {31'd0, tbl[i].e_wr});
            chk("t_mem_rd", {31'd0, mem_rd}, {31'd0, tbl[i].e_rd});
            chk("t_mem_addr", {16'd0, mem_addr}, {16'd0, tbl[i].e_addr});
            chk("t_cache_offset", {30'd0, cache_offset}, {30'd0, tbl[i].e_coff});
            chk("t_fill_valid", {31'd0, fill_valid}, {31'd0, tbl[i].e_fv});
            chk("t_fill_offset", {30'd0, fill_offset}, {30'd0, tbl[i].e_foff});
            chk("t_stall", {31'd0, stall}, {31'd0, tbl[i].e_stall});
            chk("t_done", {31'd0, done}, {31'd0, tbl[i].e_done});
            chk("t_err", {31'd0, err}, {31'd0, tbl[i].e_err});
            cyc++;
            @(posedge clk);
            #1;
        end

        // Abort the writeback left running by the table.
        start_wr = 1'b0; start_rd = 1'b0; busy = 4'h0; mem_err = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();

        // Combined writeback + fill; lines change after acceptance, a start lands on the done cycle.
        sc = 0; done_cyc = -1;
        wb_line = 13'h0001; fill_line = 13'h0002;
        for (int c = 0; c < 14; c++) begin
            start_wr = (c == 0);
            start_rd = (c == 0) || (c == 11);
            if (c == 1) begin
                wb_line = 13'h1FFF; fill_line = 13'h0AAA;
            end
            cd_base = 16'($urandom); mem_data_in = 16'($urandom);
            step();
        end
        chk("done_cycle_combined", done_cyc, 32'd11);

        // Fill with bank 1 busy in cycles 1-3.
        sc = 0; done_cyc = -1;
        fill_line = 13'h0010;
        for (int c = 0; c < 11; c++) begin
            start_wr = 1'b0;
            start_rd = (c == 0);
            busy = (c >= 1 && c <= 3) ? 4'b0010 : 4'b0000;
            mem_data_in = 16'($urandom);
            step();
        end
        chk("done_cycle_busy", done_cyc, 32'd9);

        // Reset in cycle 3 of a fill, new fill accepted in cycle 5.
        sc = 0; done_cyc = -1;
        busy = 4'h0;
        for (int c = 0; c < 15; c++) begin
            start_rd = (c == 0) || (c == 5);
            rst = (c == 3);
            mem_data_in = 16'($urandom);
            step();
        end
        rst = 1'b0;
        chk("done_cycle_after_abort", done_cyc, 32'd12);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            start_wr    = ($urandom_range(0, 9) < 3);
            start_rd    = ($urandom_range(0, 9) < 3);
            for (int b = 0; b < 4; b++) busy[b] = ($urandom_range(0, 3) == 0);
            mem_err     = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            wb_line     = 13'($urandom);
            fill_line   = 13'($urandom);
            cd_base     = 16'($urandom);
            mem_data_in = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameter: RD_LAT, default 2, cycles from mem_rd issue to mem_data_in valid; legal values 1-3.
REQ-002 Parameter: DATA_W, default 16, memory/cache word width.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_wr  in  1  request a 4-word writeback of the victim line.
REQ-007 start_rd  in  1  request a 4-word fill of the line.
REQ-008 wb_line  in  13  victim line address [15:3].
REQ-009 fill_line  in  13  fill line address [15:3].
REQ-010 cache_data  in  DATA_W  victim word at cache_offset; the cache controller drives it combinationally.
REQ-011 cache_offset  out  2  word offset being read from the cache for writeback.
REQ-012 mem_addr  out  16  {line, offset, 1'b0}.
REQ-013 mem_data_out  out  DATA_W  write data; equals cache_data.
REQ-014 mem_wr, mem_rd  out  1 each  single-cycle word access strobes; never both high.
REQ-015 mem_data_in  in  DATA_W  read data.
REQ-016 busy  in  4  per-bank busy; the bank is mem_addr[2:1].
REQ-017 mem_err  in  1  memory error flag.
REQ-018 fill_valid  out  1  fill_data is valid for fill_offset.
REQ-019 fill_offset  out  2  offset of the returned fill word.
REQ-020 fill_data  out  DATA_W  returned word (mem_data_in passthrough).
REQ-021 stall  out  1  high in every state except IDLE.
REQ-022 done  out  1  one-cycle completion pulse.
REQ-023 err  out  1  error status; valid with done.

Function
REQ-024 States: IDLE, WB, RD, DRAIN, DONE.
REQ-025 Acceptance: starts are sampled only in IDLE; starts in any other state are ignored.
REQ-026 Line latching: on acceptance, wb_line and fill_line are latched; a mid-operation change to the inputs has no effect.
REQ-027 Next state from IDLE: start_wr goes to WB (with or without start_rd); start_rd alone goes to RD.
REQ-028 Pending fill: if start_rd was high alongside start_wr, it is recorded and RD follows WB.
REQ-029 WB issue: in WB, each cycle the block issues mem_wr for the current offset (0,1,2,3 in order), with cache_offset = offset.
REQ-030 Busy stall: an issue is suppressed while busy[offset] is high; the offset holds and the issue retries next cycle.
REQ-031 WB exit: after offset 3 is issued, go to RD if a fill is pending, else DONE.
REQ-032 RD issue: in RD, the block issues mem_rd for offsets 0-3 under the same busy rule; after offset 3 is issued, go to DRAIN.
REQ-033 Return pipeline: a RD_LAT-deep shift register carries {valid, offset} per issued read.
REQ-034 Fill output: fill_valid is asserted exactly RD_LAT cycles after each mem_rd, with fill_offset equal to the issued offset.
REQ-035 DRAIN exit: DRAIN goes to DONE in the cycle after the last fill_valid.
REQ-036 DONE: done = 1 for one cycle, then IDLE; a new start in that DONE cycle is ignored.
REQ-037 Error latch: mem_err sampled in any issue cycle or fill_valid cycle sets a sticky error latch.
REQ-038 Error completion: the operation still completes all words; err = latch while done = 1, else 0; the latch clears on entry to IDLE.
REQ-039 Offset counter: 2 bits; it resets to 0 on entry to WB and to RD, with no wrap beyond 3.
REQ-040 No-stall latency, write only: issues in cycles 1-4, done in cycle 5 (cycle 0 = acceptance edge).
REQ-041 No-stall latency, read only: issues 1-4, fills 3-6, done 7 (RD_LAT=2).
REQ-042 No-stall latency, combined: writes 1-4, reads 5-8, fills 7-10, done 11.

Reset
REQ-043 Reset effect: rst forces IDLE and clears the offset, pending-fill flag, error latch and return pipeline.
REQ-044 Reset outputs: after rst, all outputs are 0 (mem_addr = 0, cache_offset = 0).
REQ-045 Reset mid-operation: rst during an operation aborts it with no done and no later fill_valid from in-flight reads.

Verification
REQ-046 start_rd, fill_line=13'h0010, busy=0 -> mem_rd at 0x0080/82/84/86 in cycles 1-4; fill_valid offsets 0-3 in cycles 3-6; done in cycle 7; err=0.
REQ-047 start_wr+start_rd, wb_line=13'h0001, fill_line=13'h0002 -> mem_wr at 0x0008-0x000E (data = cache words) in cycles 1-4; mem_rd at 0x0010-0x0016 in cycles 5-8; done in cycle 11.
REQ-048 start_rd, busy[1] high in cycles 1-3 -> offset 0 issued in cycle 1; offset 1 held until cycle 4; offsets 2,3 in cycles 5,6; done in cycle 9.
REQ-049 start_wr, mem_err pulsed in cycle 2 -> all 4 writes issued; done in cycle 5 with err=1; err=0 afterwards.
REQ-050 start_rd, rst in cycle 3 -> no fill_valid and no done afterwards; stall=0; a new start_rd in cycle 5 completes normally.
